berger_stream_checker: RTL and testbench

Parametrised, pipelined Berger-code checker for memory read-back paths. It accepts a stream of Berger codewords under valid/ready flow control and strips the check field. Each word is delivered with a per-word error flag. It also keeps a saturating error counter and a sticky error flag for software/status readout. The block sits between the memory read port and the consumer, and supports both zero-count and one-count Berger conventions.

---
 rtl/berger_stream_checker.sv | 104 ++++++++++
 tb/tb_berger_stream_checker.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/berger_stream_checker.sv
`default_nettype none
// ============================================================================
// Module  : berger_stream_checker
// Brief   : Two-stage valid/ready Berger-code checker with saturating error
//           counter and sticky error flag.
// Rev     : 1.0
// ============================================================================
module berger_stream_checker #(
    parameter int DATA_W      = 8,
    parameter int COUNT_ZEROS = 1,
    parameter int ERR_CNT_W   = 16,
    localparam int CHK_W      = $clog2(DATA_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W+CHK_W-1:0] in_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_error,
    input  logic                    clr_stats,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic                    err_sticky
);

    localparam logic [CHK_W-1:0] c_data_w = CHK_W'(DATA_W);

    function automatic logic [CHK_W-1:0] popcount(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_W; i++) begin
            n = n + CHK_W'(d[i]);
        end
        return n;
    endfunction

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_chk;
    logic [CHK_W-1:0]  r_s1_pop;

    logic              w_advance;
    logic              w_s1_load;
    logic [CHK_W-1:0]  w_expected;
    logic              w_err_xfer;

    assign w_advance  = !out_valid || out_ready;
    assign w_s1_load  = !r_s1_valid || w_advance;
    assign in_ready   = w_s1_load;
    assign w_expected = (COUNT_ZEROS != 0) ? (c_data_w - r_s1_pop) : r_s1_pop;
    assign w_err_xfer = out_valid && out_ready && out_error;

    // S1: split the codeword and count ones in the data field only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_chk   <= '0;
            r_s1_pop   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= in_code[DATA_W+CHK_W-1:CHK_W];
                r_s1_chk  <= in_code[CHK_W-1:0];
                r_s1_pop  <= popcount(in_code[DATA_W+CHK_W-1:CHK_W]);
            end
        end
    end

    // S2: full-width compare, so check values above DATA_W always mismatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_error <= 1'b0;
        end else if (w_advance) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data  <= r_s1_data;
                out_error <= (w_expected != r_s1_chk);
            end
        end
    end

    // Clear takes priority over an errored transfer in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr_stats) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (w_err_xfer) begin
            err_sticky <= 1'b1;
            if (err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_berger_stream_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_berger_stream_checker
// Brief   : Self-checking bench for berger_stream_checker.
// Rev     : 1.0
// ============================================================================
module tb_berger_stream_checker;

    localparam int DW = 8;
    localparam int CZ = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_error;
    logic        clr_stats = 1'b0;
    logic [1:0]  err_count;
    logic        err_sticky;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [20:0] b_in_code = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_data;
    logic        b_out_error;
    logic        b_clr_stats = 1'b0;
    logic [15:0] b_err_count;
    logic        b_err_sticky;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    berger_stream_checker #(.DATA_W(8), .COUNT_ZEROS(1), .ERR_CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_error(out_error),
        .clr_stats(clr_stats), .err_count(err_count), .err_sticky(err_sticky)
    );

    berger_stream_checker #(.DATA_W(16), .COUNT_ZEROS(0), .ERR_CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_error(b_out_error),
        .clr_stats(b_clr_stats), .err_count(b_err_count), .err_sticky(b_err_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Berger rule: check field must equal the zero (or one) count of the data
    function automatic logic ref_err(input logic [11:0] c);
        int ones;
        int want;
        ones = $countones(c[11:4]);
        want = (CZ != 0) ? DW - ones : ones;
        return int'(c[3:0]) != want;
    endfunction

    function automatic logic [11:0] make_code(input logic good);
        logic [7:0] d;
        logic [3:0] k;
        d = 8'($urandom);
        k = good ? 4'(DW - $countones(d)) : 4'($urandom_range(0, 15));
        return {d, k};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h err=%b, want 0 00 0", out_valid, out_data, out_error);
        end
        tests++;
        if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL reset_stats: got cnt=%0d sticky=%b, want 0 0", err_count, err_sticky);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [11:0] vec [5];
        logic        exp_e [5];
        logic [11:0] v;
        vec   = '{12'hF04, 12'h008, 12'hFF0, 12'hFF1, 12'h009};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            v = vec[i];
            in_code  = v;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_latency: out_valid=%b after 1 cycle, want 0", i, out_valid);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== v[11:4] || out_error !== exp_e[i]) begin
                fails++;
                $display("FAIL vec%0d_out: got valid=%b data=%h err=%b, want 1 %h %b",
                         i, out_valid, out_data, out_error, v[11:4], exp_e[i]);
            end
        end
        tick();
        tests++;
        if (err_count !== 2'd2 || err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL vec_stats: got cnt=%0d sticky=%b, want 2 1", err_count, err_sticky);
        end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    task automatic test_count_ones();
        logic [4:0] chk [2];
        logic       exp_e [2];
        chk   = '{5'd8, 5'd7};
        exp_e = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            b_in_code  = {16'h00FF, chk[i]};
            b_in_valid = 1'b1;
            #1;
            tests++;
            if (b_in_ready !== 1'b1) begin
                fails++;
                $display("FAIL ones%0d_ready: got %b, want 1", i, b_in_ready);
            end
            tick();
            b_in_valid = 1'b0;
            tick();
            tests++;
            if (b_out_valid !== 1'b1 || b_out_data !== 16'h00FF || b_out_error !== exp_e[i]) begin
                fails++;
                $display("FAIL ones%0d_out: got valid=%b data=%h err=%b, want 1 00ff %b",
                         i, b_out_valid, b_out_data, b_out_error, exp_e[i]);
            end
        end
        tick();
        tests++;
        if (b_err_count !== 16'd1 || b_err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL ones_stats: got cnt=%0d sticky=%b, want 1 1", b_err_count, b_err_sticky);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] w [4];
        logic [11:0] cur;
        logic [7:0]  got [$];
        int          idx;
        int          first_c;
        int          last_c;
        for (int i = 0; i < 4; i++) w[i] = make_code(1'b1);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_code  = w[idx];
            in_valid = 1'b1;
            #1;
            if (in_ready) idx++;
            tick();
        end
        tests++;
        if (idx != 2 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accepted: got %0d accepted, in_ready=%b, want 2 0", idx, in_ready);
        end
        cur = w[0];
        tests++;
        if (out_valid !== 1'b1 || out_data !== cur[11:4]) begin
            fails++;
            $display("FAIL bp_hold: got valid=%b data=%h, want 1 %h", out_valid, out_data, cur[11:4]);
        end
        out_ready = 1'b1;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 12 && got.size() < 4; c++) begin
            in_valid = (idx < 4);
            in_code  = w[idx < 4 ? idx : 3];
            #1;
            if (out_valid) begin
                got.push_back(out_data);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (got.size() != 4 || last_c - first_c != 3) begin
            fails++;
            $display("FAIL bp_drain: got %0d words over span %0d, want 4 over 3", got.size(), last_c - first_c);
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            cur = w[i];
            tests++;
            if (got[i] !== cur[11:4]) begin
                fails++;
                $display("FAIL bp_order%0d: got %h, want %h", i, got[i], cur[11:4]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c;
        out_ready = 1'b1;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_code  = (i < 5) ? 12'h000 : 12'h008;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
            tests++;
            if (err_count !== exp_c || err_sticky !== 1'b1) begin
                fails++;
                $display("FAIL sat%0d: got cnt=%0d sticky=%b, want %0d 1", i, err_count, err_sticky, exp_c);
            end
        end
    endtask

    task automatic test_clr();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        tests++;
        if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL clr_alone: got cnt=%0d sticky=%b, want 0 0", err_count, err_sticky);
        end
        in_code  = 12'hFF1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr_stats = 1'b1;
        out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b1 || out_error !== 1'b1) begin
            fails++;
            $display("FAIL clr_bus: got valid=%b err=%b, want 1 1", out_valid, out_error);
        end
        tick();
        clr_stats = 1'b0;
        tests++;
        if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL clr_vs_err: got cnt=%0d sticky=%b, want 0 0", err_count, err_sticky);
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b1;
        in_code   = 12'h000;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tests++;
        if (err_count !== 2'd1) begin
            fails++;
            $display("FAIL rst_pre_cnt: got %0d, want 1", err_count);
        end
        out_ready = 1'b0;
        in_code   = 12'h0F4;
        in_valid  = 1'b1;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_full: got in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || err_count !== 2'd0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: got valid=%b cnt=%0d sticky=%b, want 0 0 0", out_valid, err_count, err_sticky);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_release_ready: got %b, want 1", in_ready);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen++;
            tick();
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_ghost_words: got %0d words, want 0", seen);
        end
    endtask

    task automatic test_random();
        logic [8:0] sb [$];
        logic [8:0] exp_w;
        logic [1:0] m_cnt;
        logic       m_sticky;
        logic       took;
        logic       stalled;
        logic       del_err;
        m_cnt    = 2'd0;
        m_sticky = 1'b0;
        took     = 1'b0;
        stalled  = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_code  = make_code(1'($urandom_range(0, 1)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 15) == 0);
            #1;
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL rnd_stall_c%0d: out_valid dropped while stalled", c);
                end
            end
            del_err = 1'b0;
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra_c%0d: got data=%h with empty scoreboard", c, out_data);
                end else begin
                    exp_w   = sb.pop_front();
                    del_err = exp_w[8];
                    if ({out_error, out_data} !== exp_w) begin
                        fails++;
                        $display("FAIL rnd_word_c%0d: got err=%b data=%h, want %b %h",
                                 c, out_error, out_data, exp_w[8], exp_w[7:0]);
                    end
                end
            end
            took = in_valid && in_ready;
            if (took) sb.push_back({ref_err(in_code), in_code[11:4]});
            stalled = out_valid && !out_ready;
            if (clr_stats) begin
                m_cnt    = 2'd0;
                m_sticky = 1'b0;
            end else if (del_err) begin
                m_sticky = 1'b1;
                if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            end
            tick();
            tests++;
            if (err_count !== m_cnt || err_sticky !== m_sticky) begin
                fails++;
                $display("FAIL rnd_stats_c%0d: got cnt=%0d sticky=%b, want %0d %b",
                         c, err_count, err_sticky, m_cnt, m_sticky);
            end
        end
        in_valid  = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                exp_w = sb.pop_front();
                tests++;
                if ({out_error, out_data} !== exp_w) begin
                    fails++;
                    $display("FAIL rnd_drain: got err=%b data=%h, want %b %h",
                             out_error, out_data, exp_w[8], exp_w[7:0]);
                end
            end
            tick();
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL rnd_drain_timeout: %0d words left, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_count_ones();
        test_backpressure();
        test_saturation();
        test_clr();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
